logic_unit_seq: RTL and testbench

- Parametrised, handshaked successor to the combinational 32-bit AND unit.
- Performs one of eight bitwise operations on two WIDTH-bit operands. Work is done LANE bits per cycle, so one datapath slice is reused across WIDTH/LANE cycles.
- Sits between the register-read stage and the writeback mux. Upstream and downstream use valid/ready handshakes so the block can stall either side.

---
 rtl/logic_unit_seq.sv | 149 ++++++++++++++
 tb/tb_logic_unit_seq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_seq.sv
// Sequential bitwise logic unit: one of eight ops on WIDTH-bit operands, LANE bits per cycle,
// valid/ready on both sides. Optional macro LOGIC_UNIT_ACC_EN adds acc_mode (A taken from result).
module logic_unit_seq #(
    parameter int WIDTH = 32,
    parameter int LANE  = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef LOGIC_UNIT_ACC_EN
    input  logic             acc_mode,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both high;
    // the offering side holds valid and its payload until that edge.

    localparam int N     = WIDTH / LANE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] shadow_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             in_ready_q;
    logic             busy_q;
    logic             out_valid_q;

    int               slice_base;
    logic [LANE-1:0]  a_slice;
    logic [LANE-1:0]  b_slice;
    logic [LANE-1:0]  slice_res;
    logic [WIDTH-1:0] shadow_d;
    logic [WIDTH-1:0] a_src;

    // Operand A source at accept; accumulate mode chains on the last completed result.
    always_comb begin
`ifdef LOGIC_UNIT_ACC_EN
        a_src = acc_mode ? result_q : a;
`else
        a_src = a;
`endif
    end

    always_comb begin
        slice_base = int'(cnt_q) * LANE;
        a_slice    = a_q[slice_base +: LANE];
        b_slice    = b_q[slice_base +: LANE];
        case (op_q)
            3'b000:  slice_res = a_slice & b_slice;
            3'b001:  slice_res = a_slice | b_slice;
            3'b010:  slice_res = a_slice ^ b_slice;
            3'b011:  slice_res = ~(a_slice & b_slice);
            3'b100:  slice_res = ~(a_slice | b_slice);
            3'b101:  slice_res = ~(a_slice ^ b_slice);
            3'b110:  slice_res = a_slice & ~b_slice;
            default: slice_res = a_slice;
        endcase
        shadow_d = shadow_q;
        shadow_d[slice_base +: LANE] = slice_res;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            shadow_q    <= '0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q       <= op;
                        a_q        <= a_src;
                        b_q        <= b;
                        cnt_q      <= '0;
                        state_q    <= S_BUSY;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                S_BUSY: begin
                    shadow_q <= shadow_d;
                    if (cnt_q == LAST_CNT) begin
                        // Only here does the result become visible, so a reset mid-op leaks nothing.
                        result_q    <= shadow_d;
                        zero_q      <= (shadow_d == '0);
                        cnt_q       <= '0;
                        state_q     <= S_DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    cnt_q       <= '0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_logic_unit_seq.sv
// Bench for logic_unit_seq: vector table, scoreboard queue, and hand-written stall/reset sequences.
module tb_logic_unit_seq;

    localparam int WIDTH = 32;
    localparam int LANE  = 8;
    localparam int N     = WIDTH / LANE;

    logic             clock = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             acc_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             busy;
    logic [1:0]       dbg_state;

    int checks = 0;
    int errors = 0;
    logic [WIDTH:0] exp_q[$];

    typedef struct {
        logic [2:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] exp;
    } vec_t;
    vec_t vecs[12];

    logic_unit_seq #(.WIDTH(WIDTH), .LANE(LANE)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
`ifdef LOGIC_UNIT_ACC_EN
        .acc_mode  (acc_mode),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [WIDTH:0] act, input logic [WIDTH:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Scoreboard: pop one expectation per output handshake, sampled mid-cycle.
    always @(negedge clock) begin
        logic [WIDTH:0] e;
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output actual=%h expected=none", result);
            end else begin
                e = exp_q.pop_front();
                check("sb_result", {1'b0, result}, {1'b0, e[WIDTH-1:0]});
                check("sb_zero", {{WIDTH{1'b0}}, zero}, {{WIDTH{1'b0}}, e[WIDTH]});
            end
        end
    end

    // Drive one op and return #1 after its accept edge; the expectation is queued at accept.
    task automatic send(input logic [2:0] o, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic acc, input logic [WIDTH-1:0] exp);
        int n;
        @(negedge clock);
        op = o; a = av; b = bv; acc_mode = acc; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=%0d expected=<50", n);
            in_valid = 1'b0;
        end else begin
            @(posedge clock);
            exp_q.push_back({(exp == '0), exp});
            #1;
            in_valid = 1'b0;
            a = $urandom;
            b = $urandom;
            op = 3'($urandom_range(0, 7));
            acc_mode = 1'($urandom_range(0, 1));
        end
    endtask

    // Count cycles from accept to out_valid, then let the handshake complete if out_ready is high.
    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clock);
            #1;
            n++;
        end
        check({name, "_latency"}, (WIDTH+1)'(n), (WIDTH+1)'(N));
        if (out_ready) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        logic [WIDTH-1:0] hold;
        int seen;

        vecs[0]  = '{3'b000, 32'h0000FF00, 32'h0000FF00, 32'h0000FF00};
        vecs[1]  = '{3'b000, 32'h00000000, 32'h00000000, 32'h00000000};
        vecs[2]  = '{3'b000, 32'h11111111, 32'h0F0F0F0F, 32'h01010101};
        vecs[3]  = '{3'b001, 32'h11111111, 32'h0F0F0F0F, 32'h1F1F1F1F};
        vecs[4]  = '{3'b010, 32'h11111111, 32'h0F0F0F0F, 32'h1E1E1E1E};
        vecs[5]  = '{3'b011, 32'h11111111, 32'h0F0F0F0F, 32'hFEFEFEFE};
        vecs[6]  = '{3'b100, 32'h11111111, 32'h0F0F0F0F, 32'hE0E0E0E0};
        vecs[7]  = '{3'b101, 32'h11111111, 32'h0F0F0F0F, 32'hE1E1E1E1};
        vecs[8]  = '{3'b110, 32'h11111111, 32'h0F0F0F0F, 32'h10101010};
        vecs[9]  = '{3'b111, 32'h11111111, 32'h0F0F0F0F, 32'h11111111};
        vecs[10] = '{3'b110, 32'hA5C3_0FF0, 32'hA5C3_0FF0, 32'h00000000};
        vecs[11] = '{3'b010, 32'h12345678, 32'h87654321, 32'h95511559};

        reset = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; acc_mode = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst_result", {1'b0, result}, '0);
        check("rst_zero", {{WIDTH{1'b0}}, zero}, (WIDTH+1)'(1));
        check("rst_in_ready", {{WIDTH{1'b0}}, in_ready}, (WIDTH+1)'(1));
        check("rst_out_valid", {{WIDTH{1'b0}}, out_valid}, '0);
        check("rst_busy", {{WIDTH{1'b0}}, busy}, '0);

        for (int i = 0; i < 12; i++) begin
            send(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, vecs[i].exp);
            check("busy_after_accept", {{WIDTH{1'b0}}, busy}, (WIDTH+1)'(1));
            check("in_ready_busy", {{WIDTH{1'b0}}, in_ready}, '0);
            wait_done("vec");
        end

        // Backpressure: result held while downstream stalls; a second offer waits for IDLE.
        out_ready = 1'b0;
        send(3'b000, 32'h0000FF00, 32'h0F0F0F0F, 1'b0, 32'h00000F00);
        wait_done("bp");
        hold = 32'h00000F00;
        @(negedge clock);
        op = 3'b001; a = 32'h00F00000; b = 32'h0000000F; in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            check("bp_out_valid", {{WIDTH{1'b0}}, out_valid}, (WIDTH+1)'(1));
            check("bp_result", {1'b0, result}, {1'b0, hold});
            check("bp_in_ready", {{WIDTH{1'b0}}, in_ready}, '0);
        end
        @(posedge clock);
        #1 out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("bp_idle_in_ready", {{WIDTH{1'b0}}, in_ready}, (WIDTH+1)'(1));
        check("bp_idle_busy", {{WIDTH{1'b0}}, busy}, '0);
        check("bp_idle_out_valid", {{WIDTH{1'b0}}, out_valid}, '0);
        @(posedge clock);
        exp_q.push_back({1'b0, 32'h00F0000F});
        #1 in_valid = 1'b0;
        wait_done("bp2");

        // Reset mid-BUSY: the in-flight op must vanish without touching result.
        send(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF);
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b1;
        exp_q.delete();
        @(negedge clock);
        check("mid_rst_result", {1'b0, result}, '0);
        check("mid_rst_zero", {{WIDTH{1'b0}}, zero}, (WIDTH+1)'(1));
        @(posedge clock);
        #1 reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (out_valid) seen++;
        end
        check("mid_rst_no_valid", (WIDTH+1)'(seen), '0);
        check("mid_rst_result_hold", {1'b0, result}, '0);
        send(3'b010, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'h0FF00FF0);
        wait_done("post_rst");

`ifdef LOGIC_UNIT_ACC_EN
        send(3'b001, 32'h000000F0, 32'h00000000, 1'b0, 32'h000000F0);
        wait_done("acc0");
        send(3'b001, 32'hDEAD0000, 32'h0000000F, 1'b1, 32'h000000FF);
        wait_done("acc1");
        send(3'b000, 32'hFFFFFFFF, 32'h0000FFF0, 1'b1, 32'h000000F0);
        wait_done("acc2");
`endif

        repeat (3) @(negedge clock);
        check("sb_drained", (WIDTH+1)'(exp_q.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
